pipe_stage_chain: RTL and testbench

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

---
 rtl/pipe_stage_chain.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_chain.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage valid/ready pipeline with bubble collapsing,
// global stall and flush. Optional one-entry input skid: PIPE_CHAIN_SKID_EN.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   rst        - asynchronous active-high reset (clears all valid bits)
//   in_valid   - upstream beat present
//   in_data    - upstream payload (WIDTH bits)
//   in_ready   - chain accepts the beat this cycle
//   out_valid  - last stage offers a beat downstream
//   out_data   - payload of last stage (driven regardless of out_valid)
//   out_ready  - downstream accepts
//   stall      - freeze every stage this cycle
//   flush      - discard every in-flight beat at the next edge (beats stall)
//   occupancy  - number of valid entries held (includes skid entry)
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    input  logic                          stall,
    input  logic                          flush,
    output logic [$clog2(DEPTH+2)-1:0]    occupancy
);

    localparam int OCC_W = $clog2(DEPTH+2);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    logic [DEPTH-1:0] w_ready;
    logic             w_adv;
    logic             w_in_fire;
    logic             w_s0_valid;
    logic [WIDTH-1:0] w_s0_data;
    logic [OCC_W-1:0] w_occ;

    assign w_adv = ~stall & ~flush;

    // A stage is ready if it or any stage downstream of it holds a bubble,
    // or the consumer takes the last beat. Written as an OR over the
    // downstream valid bits so there is no chained self-reference.
    always_comb begin
        logic v_acc;
        v_acc   = 1'b0;
        w_ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_acc = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                v_acc = v_acc | ~r_valid[j];
            end
            w_ready[i] = v_acc;
        end
    end

`ifdef PIPE_CHAIN_SKID_EN
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    // in_ready depends only on registered skid state (rst gates it low).
    assign in_ready   = ~r_skid_valid & ~rst;
    assign w_in_fire  = in_valid & in_ready;
    // A parked skid beat always goes to stage 0 ahead of new input.
    assign w_s0_valid = r_skid_valid | w_in_fire;
    assign w_s0_data  = r_skid_valid ? r_skid_data : in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_skid_valid <= 1'b0;
        end else begin
            r_skid_valid <= w_s0_valid & ~(w_adv & w_ready[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (~r_skid_valid) begin
            r_skid_data <= in_data;
        end
    end
`else
    assign in_ready   = w_ready[0] & w_adv & ~rst;
    assign w_in_fire  = in_valid & in_ready;
    assign w_s0_valid = w_in_fire;
    assign w_s0_data  = in_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (~stall) begin
            if (w_ready[0]) begin
                r_valid[0] <= w_s0_valid;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_ready[i]) begin
                    r_valid[i] <= r_valid[i-1];
                end
            end
        end
    end

    // Payload registers carry no reset; contents of invalid stages are
    // don't-care.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            if (w_ready[0]) begin
                r_data[0] <= w_s0_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_ready[i]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(r_valid[i]);
        end
`ifdef PIPE_CHAIN_SKID_EN
        w_occ = w_occ + OCC_W'(r_skid_valid);
`endif
    end

    assign occupancy = w_occ;
    assign out_valid = r_valid[DEPTH-1] & w_adv;
    assign out_data  = r_data[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: scoreboard bench for pipe_stage_chain (DEPTH=5).
// Accepted beats are queued; every emitted beat is popped and compared.
module tb_pipe_stage_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 5;
    localparam int OW    = $clog2(DEPTH+2);
`ifdef PIPE_CHAIN_SKID_EN
    localparam int CAP   = DEPTH + 1;
`else
    localparam int CAP   = DEPTH;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             stall;
    logic             flush;
    logic [OW-1:0]    occupancy;

    pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stall     (stall),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               c;
    } ent_t;

    ent_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    bit   lat_chk     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: samples handshakes mid-cycle, when inputs are stable.
    always @(negedge clk or posedge rst) begin
        ent_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_extra: got %h, expected no beat", out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.d) begin
                        miscompares++;
                        $display("FAIL sb_data: got %h, expected %h", out_data, e.d);
                    end
                    if (lat_chk) begin
                        vectors++;
                        if (cyc - e.c != DEPTH) begin
                            miscompares++;
                            $display("FAIL sb_latency: got %0d, expected %0d",
                                     cyc - e.c, DEPTH);
                        end
                    end
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back('{in_data, cyc});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        tick(); tick();
        @(negedge clk);
        vectors += 3;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid);
        end
        if (occupancy !== '0) begin
            miscompares++; $display("FAIL rst_occupancy: got %0d, expected 0", occupancy);
        end
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready);
        end
        tick();
        rst = 1'b0; in_valid = 1'b1; in_data = 32'hEE;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL post_rst_in_ready: got %b, expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (occupancy !== OW'(1)) begin
            miscompares++; $display("FAIL first_accept: got %0d, expected 1", occupancy);
        end
        drain();
        vectors++;
        if (sb.size() != 0 || occupancy !== '0) begin
            miscompares++; $display("FAIL reset_drain: got %0d left, expected 0", sb.size());
        end
    endtask

    task automatic test_stream();
        lat_chk = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(i);
            tick();
        end
        in_valid = 1'b0;
        drain();
        lat_chk = 1'b0;
        vectors++;
        if (sb.size() != 0 || occupancy !== '0) begin
            miscompares++; $display("FAIL stream_drain: got %0d left, expected 0", sb.size());
        end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(32'h10 + i);
            tick();
        end
        in_valid = 1'b0;
        vectors += 2;
        if (occupancy !== OW'(CAP)) begin
            miscompares++; $display("FAIL fill_occupancy: got %0d, expected %0d", occupancy, CAP);
        end
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL fill_in_ready: got %b, expected 0", in_ready);
        end
        drain();
        vectors++;
        if (sb.size() != 0 || occupancy !== '0) begin
            miscompares++; $display("FAIL fill_drain: got %0d left, expected 0", sb.size());
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA0; tick();
        in_data = 32'hB0; tick();
        in_valid = 1'b0;
        repeat (DEPTH) tick();
        stall = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors += 3;
            if (out_valid !== 1'b0) begin
                miscompares++; $display("FAIL stall_out_valid: got %b, expected 0", out_valid);
            end
            if (occupancy !== OW'(2)) begin
                miscompares++; $display("FAIL stall_occupancy: got %0d, expected 2", occupancy);
            end
            if (out_data !== 32'hA0) begin
                miscompares++; $display("FAIL stall_hold: got %h, expected a0", out_data);
            end
`ifndef PIPE_CHAIN_SKID_EN
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++; $display("FAIL stall_in_ready: got %b, expected 0", in_ready);
            end
`endif
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hA0) begin
            miscompares++;
            $display("FAIL stall_release: got %b/%h, expected 1/a0", out_valid, out_data);
        end
        tick();
        drain();
        vectors++;
        if (sb.size() != 0 || occupancy !== '0) begin
            miscompares++; $display("FAIL stall_drain: got %0d left, expected 0", sb.size());
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(32'h30 + i);
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b1; stall = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL flush_out_valid: got %b, expected 0", out_valid);
        end
`ifndef PIPE_CHAIN_SKID_EN
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL flush_in_ready: got %b, expected 0", in_ready);
        end
`endif
        tick();
        flush = 1'b0; stall = 1'b0;
        vectors += 2;
        if (occupancy !== '0) begin
            miscompares++; $display("FAIL flush_occupancy: got %0d, expected 0", occupancy);
        end
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL flush_after_valid: got %b, expected 0", out_valid);
        end
        lat_chk = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h55;
        tick();
        in_valid = 1'b0;
        drain();
        lat_chk = 1'b0;
        vectors++;
        if (sb.size() != 0 || occupancy !== '0) begin
            miscompares++; $display("FAIL flush_drain: got %0d left, expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(32'h100 + i);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(32'h200 + i);
            @(negedge clk);
            vectors++;
            if (occupancy !== OW'(DEPTH)) begin
                miscompares++;
                $display("FAIL b2b_occupancy: got %0d, expected %0d", occupancy, DEPTH);
            end
            tick();
        end
        in_valid = 1'b0;
        drain();
        vectors++;
        if (sb.size() != 0 || occupancy !== '0) begin
            miscompares++; $display("FAIL b2b_drain: got %0d left, expected 0", sb.size());
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(32'h300 + i);
            tick();
        end
        #2;
        rst = 1'b1; in_valid = 1'b0;
        #1;
        vectors += 2;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL arst_out_valid: got %b, expected 0", out_valid);
        end
        if (occupancy !== '0) begin
            miscompares++; $display("FAIL arst_occupancy: got %0d, expected 0", occupancy);
        end
        #3;
        rst = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++; $display("FAIL arst_ghost: got %h, expected no beat", out_data);
            end
            tick();
        end
        in_valid = 1'b1; in_data = 32'h77;
        tick();
        in_valid = 1'b0;
        drain();
        vectors++;
        if (sb.size() != 0 || occupancy !== '0) begin
            miscompares++; $display("FAIL arst_drain: got %0d left, expected 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_stall();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
